// File: rtl/saturn_jump_unit_if.sv
// Decoder/bus <-> jump unit signal bundle.
// master: decoder/bus side drives i_*; slave: jump unit drives o_*.
`ifndef INSTR_TYPE_JUMP
`define INSTR_TYPE_JUMP 4'd3
`endif

interface saturn_jump_unit_if #(
    parameter int PC_W = 20
);
    logic [3:0]      i_phases;
    logic            i_bus_busy;
    logic [3:0]      i_instr_type;
    logic            i_instr_execute;
    logic [2:0]      i_jump_length;
    logic [2:0]      i_opcode_len;
    logic [PC_W-1:0] i_instr_pc;
    logic [3:0]      i_nibble;
    logic [PC_W-1:0] o_new_pc;
    logic            o_pc_load;
    logic            o_busy;
    logic            o_error;
`ifdef SATURN_JUMP_CALL_EN
    logic            i_jump_call;
    logic            o_rstk_push;
    logic [PC_W-1:0] o_ret_addr;
`endif

    modport master (
        output i_phases, i_bus_busy, i_instr_type, i_instr_execute,
        output i_jump_length, i_opcode_len, i_instr_pc, i_nibble,
`ifdef SATURN_JUMP_CALL_EN
        output i_jump_call,
        input  o_rstk_push, o_ret_addr,
`endif
        input  o_new_pc, o_pc_load, o_busy, o_error
    );

    modport slave (
        input  i_phases, i_bus_busy, i_instr_type, i_instr_execute,
        input  i_jump_length, i_opcode_len, i_instr_pc, i_nibble,
`ifdef SATURN_JUMP_CALL_EN
        input  i_jump_call,
        output o_rstk_push, o_ret_addr,
`endif
        output o_new_pc, o_pc_load, o_busy, o_error
    );
endinterface

// File: rtl/saturn_jump_unit.sv
// Jump unit: arms on a decoded JUMP, collects field nibbles, loads PC.
// Ports: i_clk, i_reset (sync, active-high), i_clk_en, jif (slave).
// Optional macro SATURN_JUMP_CALL_EN adds call/return-stack push.
module saturn_jump_unit #(
    parameter int PC_W    = 20,
    parameter int MAX_LEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clk_en,
    saturn_jump_unit_if.slave jif
);
    localparam int         FW   = 4 * (MAX_LEN + 1);
    localparam logic [2:0] MAXL = 3'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, COLLECT, COMPUTE, LOAD} state_t;

    state_t          state_q, state_d;
    logic [2:0]      len_q, len_d;
    logic [2:0]      olen_q, olen_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] ipc_q, ipc_d;
    logic [PC_W-1:0] new_pc_q, new_pc_d;
    logic [FW-1:0]   field_q, field_d;
    logic            load_q, load_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
`ifdef SATURN_JUMP_CALL_EN
    logic            call_q, call_d;
    logic            push_q, push_d;
    logic [PC_W-1:0] ret_q, ret_d;
`endif

    logic            arm;
    logic            len_ok;
    logic            capture;
    logic [4:0]      msb_idx;
    logic [PC_W-1:0] base;
    logic [PC_W-1:0] sext;
    logic [PC_W-1:0] target;

    assign arm = i_clk_en && jif.i_phases[3] && jif.i_instr_execute
              && (jif.i_instr_type == `INSTR_TYPE_JUMP);
    assign len_ok  = (jif.i_jump_length != 3'd0)
                  && (jif.i_jump_length <= MAXL);
    assign capture = i_clk_en && !jif.i_bus_busy && jif.i_phases[2];

    // Sign bit of the relative field is the top bit of nibble len_q.
    assign msb_idx = {len_q, 2'b11};
    assign base    = ipc_q + PC_W'(olen_q);

    always_comb begin
        sext = '0;
        for (int i = 0; i < PC_W; i++) begin
            if (i < FW && i < 4 * (int'(len_q) + 1))
                sext[i] = field_q[i];
            else
                sext[i] = field_q[msb_idx];
        end
    end

    // Additions wrap naturally at PC_W bits.
    assign target = (len_q == MAXL) ? field_q[PC_W-1:0] : base + sext;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            olen_q   <= '0;
            cnt_q    <= '0;
            ipc_q    <= '0;
            new_pc_q <= '0;
            field_q  <= '0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef SATURN_JUMP_CALL_EN
            call_q   <= 1'b0;
            push_q   <= 1'b0;
            ret_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            olen_q   <= olen_d;
            cnt_q    <= cnt_d;
            ipc_q    <= ipc_d;
            new_pc_q <= new_pc_d;
            field_q  <= field_d;
            load_q   <= load_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
`ifdef SATURN_JUMP_CALL_EN
            call_q   <= call_d;
            push_q   <= push_d;
            ret_q    <= ret_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        olen_d   = olen_q;
        cnt_d    = cnt_q;
        ipc_d    = ipc_q;
        new_pc_d = new_pc_q;
        field_d  = field_q;
        load_d   = load_q;
        busy_d   = busy_q;
        err_d    = err_q;
`ifdef SATURN_JUMP_CALL_EN
        call_d   = call_q;
        push_d   = push_q;
        ret_d    = ret_q;
`endif
        // Arming is only legal from IDLE; elsewhere it is flagged and ignored.
        if (arm && state_q != IDLE)
            err_d = 1'b1;
        if (i_clk_en) begin
            unique case (state_q)
                IDLE: begin
                    if (arm) begin
                        if (len_ok) begin
                            state_d = COLLECT;
                            len_d   = jif.i_jump_length;
                            olen_d  = jif.i_opcode_len;
                            ipc_d   = jif.i_instr_pc;
                            cnt_d   = '0;
                            field_d = '0;
                            busy_d  = 1'b1;
`ifdef SATURN_JUMP_CALL_EN
                            call_d  = jif.i_jump_call;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (capture) begin
                        field_d[{cnt_q, 2'b00} +: 4] = jif.i_nibble;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == len_q)
                            state_d = COMPUTE;
                    end
                end
                COMPUTE: begin
                    new_pc_d = target;
                    load_d   = 1'b1;
                    state_d  = LOAD;
`ifdef SATURN_JUMP_CALL_EN
                    if (call_q) begin
                        ret_d  = base + PC_W'(len_q) + PC_W'(1);
                        push_d = 1'b1;
                    end
`endif
                end
                LOAD: begin
                    load_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef SATURN_JUMP_CALL_EN
                    push_d  = 1'b0;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign jif.o_new_pc  = new_pc_q;
    assign jif.o_pc_load = load_q;
    assign jif.o_busy    = busy_q;
    assign jif.o_error   = err_q;
`ifdef SATURN_JUMP_CALL_EN
    assign jif.o_rstk_push = push_q;
    assign jif.o_ret_addr  = ret_q;
`endif
endmodule
